axi_frame_reader: RTL and testbench
===================================

AXI_FRAME_READER -- requirements
Module: axi_frame_reader

Interface
REQ-001 SHALL have parameter addr_width, default 32, meaning AXI address width (1~64).
REQ-002 SHALL have parameter data_width, default 32, meaning AXI/AXIS data width (8|16|32|64|128|256|512|1024).
REQ-003 SHALL have parameter max_burst_len, default 16, meaning maximum beats per AR burst (1~256).
REQ-004 SHALL have one clock clk; reset rst_n is synchronous, active-low.
REQ-005 SHALL provide ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- blk_start  in  1  frame start request
- blk_idle  out  1  reader idle
- blk_done  out  1  one-cycle frame-complete pulse
- frame_base  in  addr_width  frame start byte address
- frame_len  in  24  frame length in beats
- rd_err  out  1  sticky read error flag
- m_axi_araddr  out  addr_width  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arburst/arcache/arlock/arprot/arsize  out  2/4/1/3/3  constant attributes
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rdata  in  data_width;  m_axi_rresp  in  2;  m_axi_rlast  in  1
- m_axi_rvalid  in  1;  m_axi_rready  out  1
- m_axis_data  out  data_width;  m_axis_keep  out  data_width/8
- m_axis_last  out  1;  m_axis_valid  out  1;  m_axis_ready  in  1

Function
REQ-006 SHALL use states IDLE, AR, R, DONE; IDLE->AR on blk_start with frame_len!=0; IDLE->DONE on blk_start with frame_len==0; AR->R on arvalid&arready; R->AR on last beat of a non-final burst; R->DONE on last beat of final burst; DONE->IDLE unconditionally.
REQ-007 SHALL capture frame_base (low log2(data_width/8) bits forced to 0) and frame_len on accepted blk_start; blk_start outside IDLE is ignored.
REQ-008 SHALL drive blk_idle=1 only in IDLE and blk_done=1 only for the single DONE cycle.
REQ-009 SHALL set burst length = min(remaining beats, max_burst_len, beats to next 4 KB boundary); arlen = length-1.
REQ-010 SHALL hold arvalid and all AR fields stable from assertion until arready; arvalid=1 only in AR.
REQ-011 SHALL advance the next address by length*(data_width/8) bytes and reduce remaining by length after each burst completes.
REQ-012 SHALL keep exactly one burst outstanding; no AR issued while in R.
REQ-013 SHALL tie arburst=2'b01 (INCR), arcache=4'b0011, arlock=0, arprot=3'b000, arsize=log2(data_width/8).
REQ-014 SHALL pass data combinationally in R: m_axis_data=rdata, m_axis_valid=rvalid, rready=m_axis_ready; outside R, valid and rready are 0.
REQ-015 SHALL drive m_axis_keep all-ones; m_axis_last=1 only on the final beat of the frame.
REQ-016 SHALL end a burst on its internal beat count; rlast mismatching that count sets rd_err.
REQ-017 SHALL set rd_err on any accepted beat with rresp!=2'b00, clear it on an accepted blk_start, and complete the frame regardless.

Reset
REQ-018 SHALL on rst_n=0 at clk edge enter IDLE: blk_idle=1, blk_done=0, arvalid=0, rready=0, m_axis_valid=0, m_axis_last=0, rd_err=0, counters 0.
REQ-019 SHALL abandon any frame in progress on reset without completing outstanding R beats.

Verification
REQ-020 frame_base=0x1000, frame_len=40, max_burst_len=16 -> ARs at 0x1000/0x1040/0x1080, arlen 15/15/7; m_axis_last only on beat 40; blk_done one cycle later.
REQ-021 frame_base=0x0FF8, frame_len=8, data_width=32 -> AR 0x0FF8 arlen 1, then 0x1000 arlen 5 (4 KB split).
REQ-022 frame_len=0 -> no arvalid, blk_done pulses the cycle after IDLE, blk_idle returns high next cycle.
REQ-023 m_axis_ready random 50% and arready delayed 3 cycles -> AR fields stable while waiting, 40 beats delivered in order, no beat lost or duplicated.
REQ-024 rresp=2'b10 on beat 5 -> rd_err=1 from next cycle through DONE, cleared on next blk_start.
REQ-025 rst_n=0 mid-burst -> next cycle IDLE, all outputs at reset values; subsequent 16-beat frame completes normally.

Source files
------------

// File: rtl/axi_frame_reader.sv
// Single-outstanding AXI4 read master that fetches a frame of beats starting at
// frame_base and forwards them on an AXI-Stream port, splitting bursts at 4 KB.
module axi_frame_reader #(
  parameter int unsigned addr_width    = 32,
  parameter int unsigned data_width    = 32,
  parameter int unsigned max_burst_len = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    blk_start,
  output logic                    blk_idle,
  output logic                    blk_done,
  input  logic [addr_width-1:0]   frame_base,
  input  logic [23:0]             frame_len,
  output logic                    rd_err,
  output logic [addr_width-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [2:0]              m_axi_arsize,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [data_width-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [data_width-1:0]   m_axis_data,
  output logic [data_width/8-1:0] m_axis_keep,
  output logic                    m_axis_last,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready
);

  localparam int unsigned BYTES = data_width / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam logic [addr_width-1:0] ALIGN_MASK = {addr_width{1'b1}} << SIZE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [23:0]           remaining_q, remaining_d;
  logic [8:0]            burst_len_q, burst_len_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  rd_err_q, rd_err_d;

  logic [11:0] page_off;
  logic [12:0] to_boundary;
  logic [24:0] len_w;
  logic [8:0]  next_len;
  logic        in_r;
  logic        r_hs;
  logic        last_beat;
  logic        final_burst;

  if (addr_width >= 12) begin : g_page
    assign page_off = addr_q[11:0];
  end else begin : g_page_small
    assign page_off = 12'(addr_q);
  end

  // Beats left before the next 4 KB page; addr_q is always beat-aligned.
  assign to_boundary = (13'd4096 - {1'b0, page_off}) >> SIZE;

  always_comb begin
    len_w = {1'b0, remaining_q};
    if (len_w > 25'(max_burst_len)) len_w = 25'(max_burst_len);
    if (len_w > 25'(to_boundary))   len_w = 25'(to_boundary);
  end

  assign next_len    = 9'(len_w);
  assign in_r        = (state_q == S_R);
  assign r_hs        = in_r && m_axi_rvalid && m_axis_ready;
  assign last_beat   = ((beat_cnt_q + 9'd1) == burst_len_q);
  assign final_burst = (remaining_q == 24'(burst_len_q));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    rd_err_d    = rd_err_q;
    case (state_q)
      S_IDLE: begin
        if (blk_start) begin
          rd_err_d    = 1'b0;
          addr_d      = frame_base & ALIGN_MASK;
          remaining_d = frame_len;
          state_d     = (frame_len != 24'd0) ? S_AR : S_DONE;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          burst_len_d = next_len;
          beat_cnt_d  = '0;
          state_d     = S_R;
        end
      end
      S_R: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_axi_rresp != 2'b00)    rd_err_d = 1'b1;
          if (m_axi_rlast != last_beat) rd_err_d = 1'b1;
          // Burst end follows our own beat count, never rlast.
          if (last_beat) begin
            addr_d      = addr_q + (addr_width'(burst_len_q) << SIZE);
            remaining_d = remaining_q - 24'(burst_len_q);
            state_d     = final_burst ? S_DONE : S_AR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign blk_idle = (state_q == S_IDLE);
  assign blk_done = (state_q == S_DONE);
  assign rd_err   = rd_err_q;

  // AR fields derive only from addr_q/remaining_q, which hold while in AR.
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(next_len - 9'd1);
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arsize  = 3'(SIZE);

  assign m_axi_rready  = in_r && m_axis_ready;
  assign m_axis_data   = m_axi_rdata;
  assign m_axis_keep   = '1;
  assign m_axis_valid  = in_r && m_axi_rvalid;
  assign m_axis_last   = in_r && last_beat && final_burst;

endmodule

// File: tb/tb_axi_frame_reader.sv
// Scoreboard bench for axi_frame_reader: a reference model queues expected AR
// requests and stream beats, a memory-like slave answers, a monitor compares.
module tb_axi_frame_reader;

  localparam logic [31:0] DATA_KEY = 32'hA5C3_0000;

  logic        clk;
  logic        rst_n;
  logic        blk_start;
  logic        blk_idle;
  logic        blk_done;
  logic [31:0] frame_base;
  logic [23:0] frame_len;
  logic        rd_err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_arlock;
  logic [2:0]  m_axi_arprot;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axis_data;
  logic [3:0]  m_axis_keep;
  logic        m_axis_last;
  logic        m_axis_valid;
  logic        m_axis_ready;

  axi_frame_reader #(
    .addr_width   (32),
    .data_width   (32),
    .max_burst_len(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_start    (blk_start),
    .blk_idle     (blk_idle),
    .blk_done     (blk_done),
    .frame_base   (frame_base),
    .frame_len    (frame_len),
    .rd_err       (rd_err),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock (m_axi_arlock),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axis_data  (m_axis_data),
    .m_axis_keep  (m_axis_keep),
    .m_axis_last  (m_axis_last),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Stimulus knobs shared with the slave model.
  int unsigned err_beat = 0;
  int unsigned ar_delay = 0;
  int unsigned ready_pct = 100;
  int unsigned slave_beat_idx = 0;
  bit          slave_flush = 0;
  bit          in_reset = 0;

  // Monitor results.
  int unsigned beats_seen = 0;
  int unsigned last_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  bit          done_seen = 0;
  logic        err_at_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: burst splitting and the beat stream from first principles.
  task automatic model_frame(input logic [31:0] base, input int unsigned len);
    logic [31:0] a;
    int unsigned rem, n, room;
    a   = base & ~32'h3;
    rem = len;
    while (rem > 0) begin
      n    = (rem > 16) ? 16 : rem;
      room = (4096 - (a % 4096)) / 4;
      if (n > room) n = room;
      exp_ar_q.push_back('{a, 8'(n - 1)});
      a   = a + n * 4;
      rem = rem - n;
    end
    for (int unsigned k = 0; k < len; k++)
      exp_beat_q.push_back('{((base & ~32'h3) + k * 4) ^ DATA_KEY, (k == len - 1)});
  endtask

  // Slave: returns address-derived data, keeps rvalid up until accepted.
  initial begin
    ar_t         sq[$];
    int unsigned bi = 0;
    int unsigned ar_wait = 0;
    bit          ar_pend = 0;
    bit          r_pend = 0;
    bit          flushed;
    ar_t         pend_ar;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axis_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (ar_pend) begin
        sq.push_back(pend_ar);
        ar_wait = 0;
      end
      if (r_pend && sq.size() > 0) begin
        slave_beat_idx++;
        if (bi == int'(sq[0].len)) begin
          void'(sq.pop_front());
          bi = 0;
        end else bi++;
      end
      flushed = slave_flush;
      if (slave_flush) begin
        sq.delete();
        bi = 0;
        ar_wait = 0;
        slave_flush = 0;
      end
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_wait >= ar_delay);
        if (!m_axi_arready) ar_wait++;
      end else m_axi_arready = 1'b0;
      if (!(m_axi_rvalid && !r_pend) || flushed) begin
        if (sq.size() > 0 && $urandom_range(99) < 75) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = (sq[0].addr + bi * 4) ^ DATA_KEY;
          m_axi_rlast  = (bi == int'(sq[0].len));
          m_axi_rresp  = (slave_beat_idx + 1 == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rdata  = $urandom;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
      end
      m_axis_ready = ($urandom_range(99) < ready_pct);
      #1;
      ar_pend = m_axi_arvalid && m_axi_arready;
      pend_ar = '{m_axi_araddr, m_axi_arlen};
      r_pend  = m_axi_rvalid && m_axi_rready;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin
    bit          done_prev = 0;
    bit          err_pending = 0;
    bit          ar_waiting = 0;
    logic [31:0] held_addr = '0;
    logic [7:0]  held_len = '0;
    ar_t         ea;
    beat_t       eb;
    forever begin
      @(negedge clk);
      #2;
      if (in_reset) begin
        done_prev = 0;
        err_pending = 0;
        ar_waiting = 0;
        continue;
      end
      if (done_prev) begin
        chk("done_single_cycle", blk_done, 0);
        chk("idle_after_done", blk_idle, 1);
      end
      done_prev = blk_done;
      if (blk_done) begin
        done_seen   = 1;
        done_cyc    = cyc;
        err_at_done = rd_err;
      end
      if (err_pending) chk("rd_err_after_bad_resp", rd_err, 1);
      err_pending = 0;
      if (m_axi_arvalid && ar_waiting) begin
        chk("ar_addr_held", m_axi_araddr, held_addr);
        chk("ar_len_held", m_axi_arlen, held_len);
      end
      if (m_axi_arvalid && !ar_waiting) begin
        held_addr = m_axi_araddr;
        held_len  = m_axi_arlen;
      end
      ar_waiting = m_axi_arvalid && !m_axi_arready;
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ar: got addr 0x%0h len %0d, none required", m_axi_araddr, m_axi_arlen);
        end else begin
          ea = exp_ar_q.pop_front();
          chk("ar_addr", m_axi_araddr, ea.addr);
          chk("ar_len", m_axi_arlen, ea.len);
        end
      end
      if (m_axis_valid && m_axis_ready) begin
        beats_seen++;
        last_cyc = cyc;
        if (m_axi_rresp != 2'b00) err_pending = 1;
        if (exp_beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h, none required", m_axis_data);
        end else begin
          eb = exp_beat_q.pop_front();
          chk("beat_data", m_axis_data, eb.data);
          chk("beat_last", m_axis_last, eb.last);
          chk("beat_keep", m_axis_keep, 4'hF);
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input int unsigned len,
                             input int unsigned eb, input int unsigned dly, input int unsigned pct);
    @(negedge clk);
    err_beat       = eb;
    ar_delay       = dly;
    ready_pct      = pct;
    slave_beat_idx = 0;
    beats_seen     = 0;
    done_seen      = 0;
    model_frame(base, len);
    frame_base = base;
    frame_len  = 24'(len);
    blk_start  = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    blk_start = 1'b0;
    #3;
    chk("rd_err_clear_on_start", rd_err, 0);
    chk("left_idle", blk_idle, 0);
  endtask

  task automatic run_frame(input logic [31:0] base, input int unsigned len,
                           input int unsigned eb, input int unsigned dly, input int unsigned pct);
    bit exp_err;
    exp_err = (eb != 0) && (eb <= len);
    start_frame(base, len, eb, dly, pct);
    for (int i = 0; i < 4000 && !done_seen; i++) @(negedge clk);
    #3;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no blk_done, required one for base 0x%0h len %0d", base, len);
      exp_ar_q.delete();
      exp_beat_q.delete();
    end else begin
      chk("beats_delivered", beats_seen, len);
      chk("beats_outstanding", exp_beat_q.size(), 0);
      chk("ars_outstanding", exp_ar_q.size(), 0);
      chk("rd_err_at_done", err_at_done, exp_err);
      if (len == 0) chk("done_after_start", done_cyc, start_cyc + 1);
      else          chk("done_after_last", done_cyc, last_cyc + 1);
    end
    @(negedge clk);
    #3;
    chk("idle_between_frames", blk_idle, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_blk_idle", blk_idle, 1);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_axis_valid", m_axis_valid, 0);
    chk("rst_axis_last", m_axis_last, 0);
    chk("rst_rd_err", rd_err, 0);
  endtask

  initial begin
    logic [31:0] b;
    int unsigned n, e;
    rst_n      = 1'b0;
    in_reset   = 1;
    blk_start  = 1'b0;
    frame_base = '0;
    frame_len  = '0;
    repeat (3) @(negedge clk);
    #3;
    check_reset_outputs();
    chk("arburst", m_axi_arburst, 2'b01);
    chk("arcache", m_axi_arcache, 4'b0011);
    chk("arlock", m_axi_arlock, 0);
    chk("arprot", m_axi_arprot, 3'b000);
    chk("arsize", m_axi_arsize, 3'd2);
    rst_n    = 1'b1;
    in_reset = 0;

    run_frame(32'h0000_1000, 40, 0, 0, 100);
    run_frame(32'h0000_0FF8, 8, 0, 0, 100);
    run_frame(32'h0000_3000, 0, 0, 0, 100);
    run_frame(32'h0000_1000, 40, 0, 3, 50);
    run_frame(32'h0000_2004, 20, 5, 1, 70);
    run_frame(32'h0000_2004, 12, 0, 0, 90);

    // Reset in the middle of a frame.
    start_frame(32'h0000_5000, 40, 0, 0, 100);
    for (int i = 0; i < 500 && beats_seen < 5; i++) @(negedge clk);
    chk("beats_before_reset", (beats_seen >= 5), 1);
    @(negedge clk);
    rst_n       = 1'b0;
    in_reset    = 1;
    slave_flush = 1;
    exp_ar_q.delete();
    exp_beat_q.delete();
    @(negedge clk);
    #3;
    check_reset_outputs();
    rst_n    = 1'b1;
    in_reset = 0;
    run_frame(32'h0000_2000, 16, 0, 0, 100);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(1) == 0) b = $urandom & 32'h0000_FFFF;
      else b = 32'($urandom_range(15, 1) * 4096) - 32'($urandom_range(20, 0) * 4);
      n = $urandom_range(50, 0);
      e = ($urandom_range(3) == 0) ? $urandom_range(n + 1, 1) : 0;
      run_frame(b, n, e, $urandom_range(3, 0), $urandom_range(100, 30));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
